// File: rtl/tankb_ioctl_upload.sv
// tankb_ioctl_upload: answers hps_io upload requests for one ioctl index by
// pausing the game CPU and streaming bytes out of a game-side RAM read port.
//
// Ports:
//   clk_sys, reset             - system clock, synchronous active-high reset
//   ioctl_upload, ioctl_index  - upload session level and its index
//   ioctl_rd, ioctl_addr       - one-cycle byte request and its address
//   ioctl_din, ioctl_wait      - returned byte and not-ready flag
//   pause_req, pause_ack       - CPU halt handshake
//   ram_rd, ram_addr, ram_q    - RAM read port (data RD_LATENCY cycles later)
//   byte_count, xsum           - bytes delivered / XOR of delivered bytes
//   proto_err                  - sticky: request received while busy
module tankb_ioctl_upload #(
  parameter logic [7:0]  INDEX      = 8'd4,
  parameter int unsigned AW         = 10,
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  FILL       = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_q,
  output logic [15:0]   byte_count,
  output logic [7:0]    xsum,
  output logic          proto_err
);

  localparam int unsigned CW     = 3;
  localparam logic [24:0] SIZE_A = 25'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAUSE = 2'd1,
    S_READY = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [24:0]     pend_addr_q, pend_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [7:0]      din_d;
  logic            wait_d;
  logic            pause_d;
  logic            ram_rd_d;
  logic [AW-1:0]   ram_addr_d;
  logic [15:0]     count_d;
  logic [7:0]      xsum_d;
  logic            perr_d;

  logic            active;
  logic            req;
  logic [24:0]     req_addr;
  logic            in_range;
  logic            deliver;
  logic [7:0]      dbyte;

  assign active   = ioctl_upload && (ioctl_index == INDEX);
  // A request latched while pausing takes priority over a fresh strobe.
  assign req      = pend_q || ioctl_rd;
  assign req_addr = pend_q ? pend_addr_q : ioctl_addr;
  assign in_range = req_addr < SIZE_A;

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      cnt_q       <= '0;
      ioctl_din   <= '0;
      ioctl_wait  <= 1'b0;
      pause_req   <= 1'b0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      byte_count  <= '0;
      xsum        <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
      ioctl_din   <= din_d;
      ioctl_wait  <= wait_d;
      pause_req   <= pause_d;
      ram_rd      <= ram_rd_d;
      ram_addr    <= ram_addr_d;
      byte_count  <= count_d;
      xsum        <= xsum_d;
      proto_err   <= perr_d;
    end
  end

  // Next-state logic; losing the session always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_PAUSE;
        S_PAUSE: if (pause_ack) state_d = S_READY;
        S_READY: if (req && in_range) state_d = S_FETCH;
        S_FETCH: if (cnt_q == '0) state_d = S_READY;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    din_d       = ioctl_din;
    wait_d      = ioctl_wait;
    pause_d     = pause_req;
    ram_rd_d    = 1'b0;
    ram_addr_d  = ram_addr;
    count_d     = byte_count;
    xsum_d      = xsum;
    perr_d      = proto_err;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    deliver     = 1'b0;
    dbyte       = '0;

    if (!active) begin
      // Abandon any in-flight fetch; data, count and checksum stay visible.
      pause_d = 1'b0;
      wait_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pause_d = 1'b1;
          wait_d  = 1'b1;
          count_d = '0;
          xsum_d  = '0;
          perr_d  = 1'b0;
          pend_d  = 1'b0;
        end
        S_PAUSE: begin
          if (ioctl_rd) begin
            if (pend_q) begin
              perr_d = 1'b1;
            end else begin
              pend_d      = 1'b1;
              pend_addr_d = ioctl_addr;
            end
          end
          if (pause_ack) wait_d = 1'b0;
        end
        S_READY: begin
          if (req) begin
            pend_d = 1'b0;
            if (pend_q && ioctl_rd) perr_d = 1'b1;
            if (in_range) begin
              ram_rd_d   = 1'b1;
              ram_addr_d = req_addr[AW-1:0];
              wait_d     = 1'b1;
              cnt_d      = CW'(RD_LATENCY);
            end else begin
              deliver = 1'b1;
              dbyte   = FILL;
            end
          end
        end
        S_FETCH: begin
          if (ioctl_rd) perr_d = 1'b1;
          if (cnt_q == '0) begin
            deliver = 1'b1;
            dbyte   = ram_q;
            wait_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end

    // Byte delivery: count saturates, checksum folds in every byte.
    if (deliver) begin
      din_d   = dbyte;
      count_d = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
      xsum_d  = xsum ^ dbyte;
    end
  end

endmodule

// File: tb/tb_tankb_ioctl_upload.sv
module tb_tankb_ioctl_upload;

  localparam int unsigned L    = 2;
  localparam int unsigned AW   = 10;
  localparam int unsigned SZ   = 1000;
  localparam logic [7:0]  IDX  = 8'd4;
  localparam logic [7:0]  FILB = 8'hFF;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          pause_ack;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q;
  logic [15:0]   byte_count;
  logic [7:0]    xsum;
  logic          proto_err;

  always #5 clk_sys = ~clk_sys;

  tankb_ioctl_upload #(
    .INDEX(IDX), .AW(AW), .SIZE(SZ), .RD_LATENCY(L), .FILL(FILB)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q),
    .byte_count(byte_count), .xsum(xsum), .proto_err(proto_err)
  );

  // RAM: data for a read strobe is valid for one cycle, L cycles later;
  // random garbage otherwise so early/late sampling shows up.
  logic [7:0] mem [0:1023];
  logic [L:1] vpipe = '0;
  logic [7:0] dpipe [1:L];
  logic [7:0] rnd = 8'h00;
  always @(posedge clk_sys) begin
    vpipe[1] <= ram_rd;
    dpipe[1] <= mem[ram_addr];
    for (int i = 2; i <= int'(L); i++) begin
      vpipe[i] <= vpipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
    rnd <= 8'($urandom);
  end
  assign ram_q = vpipe[L] ? dpipe[L] : rnd;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // Transaction-level reference: session, pause handshake, pending request
  // and a fetch that completes at a fixed cycle L+1 after acceptance.
  bit         chk_en = 0;
  int         cyc = 0;
  bit         sess = 0, acked = 0, pend = 0, fetching = 0;
  logic [24:0] paddr = '0;
  logic [9:0] faddr = '0;
  int         done_cyc = 0;
  logic [7:0] e_din = 0, e_xsum = 0;
  logic [15:0] e_cnt = 0;
  logic       e_wait = 0, e_pause = 0, e_ram_rd = 0, e_perr = 0;
  logic [9:0] e_ram_addr = 0;

  function automatic void deliver(input logic [7:0] b);
    e_din = b;
    if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    e_xsum = e_xsum ^ b;
  endfunction

  initial begin
    forever begin
      @(posedge clk_sys);
      cyc++;
      if (reset) begin
        chk_en = 1;
        sess = 0; acked = 0; pend = 0; fetching = 0;
        e_din = 0; e_xsum = 0; e_cnt = 0; e_wait = 0; e_pause = 0;
        e_ram_rd = 0; e_perr = 0; e_ram_addr = 0;
      end else begin
        bit act;
        logic [24:0] a;
        act = ioctl_upload && (ioctl_index == IDX);
        e_ram_rd = 0;
        if (!act) begin
          sess = 0; acked = 0; pend = 0; fetching = 0;
          e_pause = 0; e_wait = 0;
        end else if (!sess) begin
          sess = 1; acked = 0; pend = 0; fetching = 0;
          e_pause = 1; e_wait = 1; e_cnt = 0; e_xsum = 0; e_perr = 0;
        end else if (!acked) begin
          if (ioctl_rd) begin
            if (pend) e_perr = 1;
            else begin pend = 1; paddr = ioctl_addr; end
          end
          if (pause_ack) begin acked = 1; e_wait = 0; end
        end else if (fetching) begin
          if (ioctl_rd) e_perr = 1;
          if (cyc == done_cyc) begin
            deliver(mem[faddr]);
            e_wait = 0;
            fetching = 0;
          end
        end else if (pend || ioctl_rd) begin
          a = pend ? paddr : ioctl_addr;
          if (pend && ioctl_rd) e_perr = 1;
          pend = 0;
          if (a < 25'(SZ)) begin
            e_ram_rd = 1; e_ram_addr = a[9:0]; faddr = a[9:0];
            e_wait = 1; fetching = 1; done_cyc = cyc + int'(L) + 1;
          end else begin
            deliver(FILB);
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        chk("din", 32'(ioctl_din), 32'(e_din));
        chk("wait", 32'(ioctl_wait), 32'(e_wait));
        chk("pause_req", 32'(pause_req), 32'(e_pause));
        chk("ram_rd", 32'(ram_rd), 32'(e_ram_rd));
        chk("byte_count", 32'(byte_count), 32'(e_cnt));
        chk("xsum", 32'(xsum), 32'(e_xsum));
        chk("proto_err", 32'(proto_err), 32'(e_perr));
        if (e_ram_rd) chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic req(input logic [24:0] a);
    ioctl_rd = 1; ioctl_addr = a;
    tick();
    ioctl_rd = 0;
  endtask

  initial begin
    reset = 1; ioctl_upload = 0; ioctl_index = 0; ioctl_rd = 0;
    ioctl_addr = 0; pause_ack = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    chk("lit_rst_din", 32'(ioctl_din), 32'h0);
    chk("lit_rst_wait", 32'(ioctl_wait), 32'h0);
    chk("lit_rst_preq", 32'(pause_req), 32'h0);
    chk("lit_rst_cnt", 32'(byte_count), 32'h0);
    reset = 0;
    tick();

    // Delayed ack with a request queued during the pause.
    mem[3] = 8'h5A;
    ioctl_upload = 1; ioctl_index = IDX;
    tick();
    chk("lit_start_preq", 32'(pause_req), 32'h1);
    chk("lit_start_wait", 32'(ioctl_wait), 32'h1);
    req(25'd3);
    repeat (3) tick();
    chk("lit_pause_wait", 32'(ioctl_wait), 32'h1);
    pause_ack = 1;
    tick();
    chk("lit_ack_wait", 32'(ioctl_wait), 32'h0);
    repeat (L + 2) tick();
    chk("lit_pend_din", 32'(ioctl_din), 32'h5A);
    chk("lit_pend_cnt", 32'(byte_count), 32'h1);

    // Sequential reads in a fresh session.
    ioctl_upload = 0; tick();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[999] = 8'hC3;
    ioctl_upload = 1; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] expb;
      expb = 8'((i + 1) * 8'h11);
      req(25'(i));
      chk("lit_seq_ram_rd", 32'(ram_rd), 32'h1);
      repeat (L + 1) tick();
      chk("lit_seq_din", 32'(ioctl_din), 32'(expb));
    end
    chk("lit_seq_xsum", 32'(xsum), 32'h44);
    chk("lit_seq_cnt", 32'(byte_count), 32'h4);

    // Out-of-range addresses return FILL immediately; 999 is the last valid.
    req(25'd1024);
    chk("lit_oor1_din", 32'(ioctl_din), 32'hFF);
    chk("lit_oor1_wait", 32'(ioctl_wait), 32'h0);
    req(25'h1000000);
    chk("lit_oor2_din", 32'(ioctl_din), 32'hFF);
    chk("lit_oor2_ram_rd", 32'(ram_rd), 32'h0);
    req(25'd1000);
    chk("lit_oor3_din", 32'(ioctl_din), 32'hFF);
    req(25'd999);
    repeat (L + 1) tick();
    chk("lit_last_din", 32'(ioctl_din), 32'hC3);
    chk("lit_last_cnt", 32'(byte_count), 32'h8);
    chk("lit_last_xsum", 32'(xsum), 32'h78);

    // Request repeated one cycle into a fetch.
    mem[5] = 8'h66;
    req(25'd5);
    req(25'd6);
    chk("lit_dup_ram_rd", 32'(ram_rd), 32'h0);
    repeat (L) tick();
    chk("lit_dup_perr", 32'(proto_err), 32'h1);
    chk("lit_dup_din", 32'(ioctl_din), 32'h66);
    ioctl_upload = 0; tick();
    ioctl_upload = 1; tick();
    chk("lit_new_perr", 32'(proto_err), 32'h0);
    chk("lit_new_cnt", 32'(byte_count), 32'h0);

    // Wrong index, then session dropped mid-fetch.
    ioctl_upload = 0; tick();
    ioctl_index = 8'd0; ioctl_upload = 1;
    repeat (4) tick();
    chk("lit_wrongidx_preq", 32'(pause_req), 32'h0);
    ioctl_index = IDX; tick(); tick();
    mem[7] = 8'h77;
    req(25'd7);
    tick();
    ioctl_upload = 0; tick();
    chk("lit_drop_preq", 32'(pause_req), 32'h0);
    chk("lit_drop_din", 32'(ioctl_din), 32'h66);
    repeat (L + 1) tick();
    chk("lit_drop_din_late", 32'(ioctl_din), 32'h66);

    // Reset during a fetch.
    ioctl_upload = 1; tick(); tick();
    req(25'd9);
    tick();
    reset = 1; ioctl_upload = 0; tick();
    chk("lit_rstf_din", 32'(ioctl_din), 32'h0);
    chk("lit_rstf_wait", 32'(ioctl_wait), 32'h0);
    chk("lit_rstf_preq", 32'(pause_req), 32'h0);
    chk("lit_rstf_ram_rd", 32'(ram_rd), 32'h0);
    chk("lit_rstf_ram_addr", 32'(ram_addr), 32'h0);
    reset = 0;
    repeat (L + 2) tick();
    chk("lit_rstf_din_late", 32'(ioctl_din), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        ioctl_upload = ~ioctl_upload;
        ioctl_index = ($urandom_range(0, 9) == 0) ? 8'($urandom) : IDX;
      end
      if ($urandom_range(0, 4) == 0) pause_ack = 1'($urandom);
      reset = ($urandom_range(0, 999) == 0);
      ioctl_rd = 0;
      if ((!ioctl_wait && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0) begin
        int unsigned k;
        ioctl_rd = 1;
        k = $urandom_range(0, 19);
        if (k < 14)      ioctl_addr = 25'($urandom_range(0, SZ - 1));
        else if (k < 17) ioctl_addr = 25'(SZ + $urandom_range(0, 30));
        else             ioctl_addr = 25'($urandom);
      end
      tick();
    end
    ioctl_rd = 0; reset = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
